// File: rtl/msrh_rob_mc.sv
// msrh_rob_mc: group-based reorder buffer with multi-group retire and exception flush.
// Define MSRH_ROB_MC_PERF_CNT_EN to add saturating retire/full/flush performance counters.
module msrh_rob_mc #(
  parameter int ENTRY_SIZE = 16,
  parameter int GRP_W = 2,
  parameter int CMT_W = 2,
  parameter int DONE_PORTS = 4,
  parameter int VADDR_W = 39,
  localparam int ID_W = $clog2(ENTRY_SIZE) + 1
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset_n,
  input  logic                                 i_disp_valid,
  input  logic [GRP_W-1:0]                     i_disp_grp_id,
  input  logic [VADDR_W-1:0]                   i_disp_pc,
  output logic                                 o_disp_ready,
  output logic [ID_W-1:0]                      o_new_cmt_id,
  input  logic [DONE_PORTS-1:0]                i_done_valid,
  input  logic [DONE_PORTS-1:0][ID_W-1:0]      i_done_cmt_id,
  input  logic [DONE_PORTS-1:0][GRP_W-1:0]     i_done_grp_id,
  input  logic [DONE_PORTS-1:0]                i_done_except,
  output logic [CMT_W-1:0]                     o_cmt_valid,
  output logic [CMT_W-1:0][ID_W-1:0]           o_cmt_id,
  output logic [CMT_W-1:0][GRP_W-1:0]          o_cmt_grp_id,
  output logic                                 o_flush_valid,
  output logic [VADDR_W-1:0]                   o_flush_pc
`ifdef MSRH_ROB_MC_PERF_CNT_EN
  ,
  output logic [31:0]                          o_perf_retired,
  output logic [31:0]                          o_perf_full_cycles,
  output logic [31:0]                          o_perf_flushes
`endif
);
  localparam int IDX_W = ID_W - 1;
  typedef enum logic {RUN, FLUSH} state_t;
  state_t r_state;
  logic [ID_W-1:0] r_in_ptr, r_out_ptr, w_count, w_cmt_cnt;
  logic [ENTRY_SIZE-1:0] r_valid;
  logic [VADDR_W-1:0] r_pc [ENTRY_SIZE];
  logic [GRP_W-1:0] r_grp [ENTRY_SIZE];
  logic [GRP_W-1:0] r_done [ENTRY_SIZE];
  logic [GRP_W-1:0] r_exc [ENTRY_SIZE];
  logic [GRP_W-1:0] w_done_set [ENTRY_SIZE];
  logic [GRP_W-1:0] w_exc_set [ENTRY_SIZE];
  logic [IDX_W-1:0] w_idx, w_in_idx;
  logic [GRP_W-1:0] w_lsb;
  logic [VADDR_W-1:0] w_off;
  logic w_full, w_disp, w_ok;
  assign w_count = r_in_ptr - r_out_ptr;
  assign w_full = w_count == ID_W'(ENTRY_SIZE);
  assign o_disp_ready = !w_full && r_state == RUN;
  assign o_new_cmt_id = r_in_ptr;
  assign w_in_idx = r_in_ptr[IDX_W-1:0];
  assign w_disp = i_disp_valid && o_disp_ready && !o_flush_valid;
  always_comb begin
    for (int i = 0; i < ENTRY_SIZE; i++) begin
      w_done_set[i] = '0;
      w_exc_set[i] = '0;
      for (int p = 0; p < DONE_PORTS; p++) begin
        w_done_set[i] = w_done_set[i] | ((i_done_valid[p] && i_done_cmt_id[p][IDX_W-1:0] == IDX_W'(i)) ? i_done_grp_id[p] : '0);
        w_exc_set[i] = w_exc_set[i] | ((i_done_valid[p] && i_done_except[p] && i_done_cmt_id[p][IDX_W-1:0] == IDX_W'(i)) ? i_done_grp_id[p] : '0);
      end
    end
  end
  // Retire chain: each slot needs every older slot retiring and no older exception.
  always_comb begin
    o_cmt_valid = '0;
    o_cmt_id = '0;
    o_cmt_grp_id = '0;
    o_flush_valid = 1'b0;
    o_flush_pc = '0;
    w_cmt_cnt = '0;
    w_idx = '0;
    w_lsb = '0;
    w_off = '0;
    w_ok = r_state == RUN;
    for (int k = 0; k < CMT_W; k++) begin
      o_cmt_id[k] = r_out_ptr + ID_W'(k);
      w_idx = o_cmt_id[k][IDX_W-1:0];
      w_lsb = r_exc[w_idx] & (~r_exc[w_idx] + 1'b1);
      w_off = '0;
      for (int b = 0; b < GRP_W; b++) w_off = w_lsb[b] ? VADDR_W'(4 * b) : w_off;
      w_ok = w_ok && ID_W'(k) < w_count && r_valid[w_idx] && r_done[w_idx] == r_grp[w_idx];
      o_cmt_valid[k] = w_ok;
      o_cmt_grp_id[k] = w_ok ? r_grp[w_idx] & (w_lsb | (w_lsb - 1'b1)) : '0;
      w_cmt_cnt = w_cmt_cnt + ID_W'(w_ok);
      o_flush_pc = (w_ok && |w_lsb) ? r_pc[w_idx] + w_off : o_flush_pc;
      o_flush_valid = o_flush_valid || (w_ok && |w_lsb);
      w_ok = w_ok && !(|w_lsb);
    end
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= RUN;
      r_in_ptr <= '0;
      r_out_ptr <= '0;
      r_valid <= '0;
      for (int i = 0; i < ENTRY_SIZE; i++) begin
        r_pc[i] <= '0;
        r_grp[i] <= '0;
        r_done[i] <= '0;
        r_exc[i] <= '0;
      end
    end else if (r_state == FLUSH) begin
      r_state <= RUN;
      r_valid <= '0;
      r_in_ptr <= r_out_ptr;
    end else begin
      for (int i = 0; i < ENTRY_SIZE; i++) begin
        if (r_valid[i]) begin
          r_done[i] <= r_done[i] | w_done_set[i];
          r_exc[i] <= r_exc[i] | w_exc_set[i];
        end
      end
      for (int k = 0; k < CMT_W; k++) begin
        if (o_cmt_valid[k]) r_valid[o_cmt_id[k][IDX_W-1:0]] <= 1'b0;
      end
      r_out_ptr <= r_out_ptr + w_cmt_cnt;
      r_state <= o_flush_valid ? FLUSH : RUN;
      if (w_disp) begin
        r_valid[w_in_idx] <= 1'b1;
        r_pc[w_in_idx] <= i_disp_pc;
        r_grp[w_in_idx] <= i_disp_grp_id;
        r_done[w_in_idx] <= '0;
        r_exc[w_in_idx] <= '0;
        r_in_ptr <= r_in_ptr + 1'b1;
      end
    end
  end
`ifdef MSRH_ROB_MC_PERF_CNT_EN
  logic [31:0] w_ret_sum;
  assign w_ret_sum = o_perf_retired + 32'(w_cmt_cnt);
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_perf_retired <= '0;
      o_perf_full_cycles <= '0;
      o_perf_flushes <= '0;
    end else begin
      o_perf_retired <= (w_ret_sum < o_perf_retired) ? '1 : w_ret_sum;
      o_perf_full_cycles <= o_perf_full_cycles + 32'(w_full && o_perf_full_cycles != '1);
      o_perf_flushes <= o_perf_flushes + 32'(o_flush_valid && o_perf_flushes != '1);
    end
  end
`endif
endmodule

// File: tb/tb_msrh_rob_mc.sv
// tb_msrh_rob_mc: directed scenarios then random traffic, checked against a queue-based ROB model.
module tb_msrh_rob_mc;
  localparam int ES = 16;
  logic clk = 1'b0;
  logic rst_n;
  logic disp_valid;
  logic [1:0] disp_grp;
  logic [38:0] disp_pc;
  logic ready;
  logic [4:0] new_id;
  logic [3:0] dv;
  logic [3:0][4:0] did;
  logic [3:0][1:0] dgrp;
  logic [3:0] dexc;
  logic [1:0] cv;
  logic [1:0][4:0] cid;
  logic [1:0][1:0] cgrp;
  logic fv;
  logic [38:0] fpc;
`ifdef MSRH_ROB_MC_PERF_CNT_EN
  logic [31:0] p_ret, p_full, p_fl;
`endif
  always #5 clk = ~clk;
  msrh_rob_mc dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_disp_valid(disp_valid), .i_disp_grp_id(disp_grp), .i_disp_pc(disp_pc),
    .o_disp_ready(ready), .o_new_cmt_id(new_id),
    .i_done_valid(dv), .i_done_cmt_id(did), .i_done_grp_id(dgrp), .i_done_except(dexc),
    .o_cmt_valid(cv), .o_cmt_id(cid), .o_cmt_grp_id(cgrp),
    .o_flush_valid(fv), .o_flush_pc(fpc)
`ifdef MSRH_ROB_MC_PERF_CNT_EN
    , .o_perf_retired(p_ret), .o_perf_full_cycles(p_full), .o_perf_flushes(p_fl)
`endif
  );
  typedef struct {
    logic [38:0] pc;
    logic [1:0] grp;
    logic [1:0] done;
    logic [1:0] exc;
  } ent_t;
  ent_t rob[$];
  int out_id;
  bit flushing;
  int checks = 0;
  int errors = 0;
  logic [1:0] e_valid;
  int e_n;
  bit e_flush;
  logic [38:0] e_pc;
  logic [1:0] e_grp [2];
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic void compute_exp();
    e_valid = '0;
    e_n = 0;
    e_flush = 1'b0;
    e_pc = '0;
    e_grp[0] = '0;
    e_grp[1] = '0;
    if (!flushing) begin
      for (int k = 0; k < 2; k++) begin
        if (k >= rob.size() || e_flush) break;
        if (rob[k].done != rob[k].grp) break;
        e_valid[k] = 1'b1;
        e_n++;
        e_grp[k] = rob[k].grp;
        if (rob[k].exc != 2'b00) begin
          int l = rob[k].exc[0] ? 0 : 1;
          e_flush = 1'b1;
          e_pc = rob[k].pc + 39'(4 * l);
          e_grp[k] = rob[k].grp & 2'((2 << l) - 1);
        end
      end
    end
  endfunction
  task automatic update();
    int sz = rob.size();
    bit rdy = sz != ES;
    if (flushing) begin
      rob.delete();
      flushing = 1'b0;
      return;
    end
    for (int p = 0; p < 4; p++) begin
      if (dv[p]) begin
        int off = (int'(did[p]) - out_id + 32) % 32;
        if (off < sz) begin
          ent_t e = rob[off];
          e.done = e.done | dgrp[p];
          if (dexc[p]) e.exc = e.exc | dgrp[p];
          rob[off] = e;
        end
      end
    end
    repeat (e_n) void'(rob.pop_front());
    out_id = (out_id + e_n) % 32;
    if (e_flush) flushing = 1'b1;
    else if (disp_valid && rdy) rob.push_back('{disp_pc, disp_grp, 2'b00, 2'b00});
  endtask
  task automatic cyc();
    compute_exp();
    chk("disp_ready", ready, (!flushing && rob.size() != ES));
    chk("new_cmt_id", new_id, (out_id + rob.size()) % 32);
    chk("cmt_valid", cv, e_valid);
    for (int k = 0; k < 2; k++) begin
      if (e_valid[k]) begin
        chk("cmt_id", cid[k], (out_id + k) % 32);
        chk("cmt_grp_id", cgrp[k], e_grp[k]);
      end
    end
    chk("flush_valid", fv, e_flush);
    if (e_flush) chk("flush_pc", fpc, e_pc);
    @(posedge clk);
    update();
    @(negedge clk);
  endtask
  task automatic clear_in();
    disp_valid = 1'b0;
    disp_grp = '0;
    disp_pc = '0;
    dv = '0;
    did = '0;
    dgrp = '0;
    dexc = '0;
  endtask
  task automatic disp(logic [38:0] pc, logic [1:0] g);
    disp_valid = 1'b1;
    disp_pc = pc;
    disp_grp = g;
  endtask
  task automatic done(int p, int id, logic [1:0] g, logic x);
    dv[p] = 1'b1;
    did[p] = 5'(id);
    dgrp[p] = g;
    dexc[p] = x;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    clear_in();
    rob.delete();
    out_id = 0;
    flushing = 1'b0;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_new_id", new_id, 0);
    chk("rst_cmt_valid", cv, 0);
    chk("rst_flush_valid", fv, 0);
    chk("rst_flush_pc", fpc, 0);
`ifdef MSRH_ROB_MC_PERF_CNT_EN
    chk("rst_perf_retired", p_ret, 0);
    chk("rst_perf_full", p_full, 0);
    chk("rst_perf_flushes", p_fl, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic rand_cycle();
    clear_in();
    disp_valid = $urandom_range(0, 2) != 0;
    disp_grp = 2'($urandom_range(1, 3));
    disp_pc = 39'($urandom) << 2;
    for (int p = 0; p < 4; p++) begin
      if ($urandom_range(0, 1) == 1) begin
        int off;
        logic [1:0] g;
        off = $urandom_range(0, 15);
        g = (off < rob.size()) ? rob[off].grp : 2'b11;
        if (g == 2'b11) g = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
        done(p, (out_id + off) % 32, g, $urandom_range(0, 15) == 0);
      end
    end
    cyc();
  endtask
  initial begin
    rst_n = 1'b1;
    clear_in();
    @(negedge clk);
    // three full groups retire two then one
    do_reset();
    for (int i = 0; i < 3; i++) begin
      clear_in(); disp(39'(32'h100 * (i + 1)), 2'b11); cyc();
    end
    clear_in();
    for (int p = 0; p < 3; p++) done(p, p, 2'b11, 1'b0);
    cyc();
    clear_in();
    chk("t1_first_retire", cv, 2'b11);
    cyc();
    chk("t1_second_retire", cv, 2'b01);
    cyc();
    chk("t1_idle", cv, 2'b00);
    cyc();
    // fill to full, overflow dispatch dropped, then drain
    do_reset();
    for (int i = 0; i < 16; i++) begin
      clear_in(); disp(39'(32'h40 * i), 2'b01); cyc();
    end
    chk("t2_full_ready", ready, 0);
    chk("t2_full_id", new_id, 16);
    disp(39'h7777, 2'b01);
    cyc();
    chk("t2_drop_id", new_id, 16);
    for (int j = 0; j < 4; j++) begin
      clear_in();
      for (int p = 0; p < 4; p++) done(p, j * 4 + p, 2'b01, 1'b0);
      cyc();
    end
    clear_in();
    for (int n = 0; n < 40 && rob.size() != 0; n++) cyc();
    chk("t2_drained_ready", ready, 1);
    chk("t2_drained_id", new_id, 16);
    // exception at slot 1 flushes, coincident dispatch dropped
    do_reset();
    clear_in(); disp(39'h0f00, 2'b01); cyc();
    clear_in(); disp(39'h1000, 2'b11); cyc();
    clear_in(); disp(39'h2000, 2'b01); cyc();
    clear_in();
    done(0, 0, 2'b01, 1'b0);
    done(1, 1, 2'b01, 1'b0);
    done(2, 1, 2'b10, 1'b1);
    cyc();
    clear_in();
    chk("t3_cmt_valid", cv, 2'b11);
    chk("t3_flush", fv, 1);
    chk("t3_flush_pc", fpc, 39'h1004);
    disp(39'h3000, 2'b01);
    cyc();
    clear_in();
    chk("t3_flush_ready", ready, 0);
    cyc();
    chk("t3_empty_ready", ready, 1);
    chk("t3_empty_id", new_id, 2);
    cyc();
    // out-of-order completion
    do_reset();
    for (int i = 0; i < 3; i++) begin
      clear_in(); disp(39'(32'h800 + 8 * i), 2'b01); cyc();
    end
    clear_in(); done(0, 2, 2'b01, 1'b0); cyc();
    clear_in(); chk("t4_wait2", cv, 2'b00); done(0, 1, 2'b01, 1'b0); cyc();
    clear_in(); chk("t4_wait1", cv, 2'b00); done(0, 0, 2'b01, 1'b0); cyc();
    clear_in(); chk("t4_pair", cv, 2'b11); cyc();
    chk("t4_last", cv, 2'b01); cyc();
    // steady dispatch/retire across pointer wrap
    do_reset();
    for (int i = 0; i < 40; i++) begin
      clear_in();
      disp(39'(4 * i), 2'b01);
      if (i > 0) done(0, (i - 1) % 32, 2'b01, 1'b0);
      cyc();
      chk("t5_ready", ready, 1);
    end
    clear_in(); done(0, 39 % 32, 2'b01, 1'b0); cyc();
    clear_in(); cyc(); cyc();
    chk("t5_wrap_id", new_id, 8);
    // reset during the flush cycle
    do_reset();
    clear_in(); disp(39'h500, 2'b01); cyc();
    clear_in(); done(0, 0, 2'b01, 1'b1); cyc();
    clear_in();
    chk("t6_flush", fv, 1);
    cyc();
    chk("t6_in_flush", ready, 0);
    do_reset();
    cyc();
    // random traffic
    for (int i = 0; i < 2000; i++) rand_cycle();
    clear_in();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
